// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator bus: control from hazard/branch/CP0 logic,
// registered fetch PC and status back to the IF stage.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             stall_i;
    logic             br_taken_i;
    logic [WIDTH-1:0] br_target_i;
    logic             exc_i;
    logic             eret_i;
    logic [WIDTH-1:0] epc_i;
    logic             halt_i;
    logic [WIDTH-1:0] pc_o;
    logic             pc_valid_o;
    logic             adel_o;
    logic [1:0]       state_o;

    // Control side: hazard unit, branch unit, CP0
    modport master (
        output stall_i, br_taken_i, br_target_i, exc_i, eret_i, epc_i, halt_i,
        input  pc_o, pc_valid_o, adel_o, state_o
    );

    // PC generator side
    modport slave (
        input  stall_i, br_taken_i, br_target_i, exc_i, eret_i, epc_i, halt_i,
        output pc_o, pc_valid_o, adel_o, state_o
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: next-PC selection
// (sequential, branch, exception vector, ERET), boot/run/halt control,
// registered fetch-valid and misaligned-fetch flags.
module pc_gen #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC     = 32'h0000_4180,
    parameter int               STEP        = 4,
    parameter int               BOOT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           state_q, state_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [WIDTH-1:0] pc_q, pc_n;
    logic             valid_q;
    logic             adel_q;

    // Word fetches need the two low PC bits clear.
    function automatic logic misaligned(input logic [WIDTH-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    // Next state, next PC and boot counter from the current state and controls.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pc_n    = pc_q;
        case (state_q)
            S_BOOT: begin
                cnt_n = cnt_q + 4'd1;
                if (cnt_q == BOOT_LAST)
                    state_n = S_RUN;
            end
            S_RUN: begin
                if (bus.exc_i)
                    pc_n = EXC_VEC;
                else if (bus.eret_i)
                    pc_n = bus.epc_i;
                else if (bus.br_taken_i)
                    pc_n = bus.br_target_i;
                else if (bus.halt_i)
                    state_n = S_HALT;
                else if (!bus.stall_i)
                    pc_n = pc_q + STEP_W;
            end
            S_HALT: begin
                // Only an interrupt/exception wakes a halted core.
                if (bus.exc_i) begin
                    pc_n    = EXC_VEC;
                    state_n = S_RUN;
                end
            end
            default: begin
                // Illegal encoding: restart the boot sequence.
                state_n = S_BOOT;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // State, PC and registered status flags; reset dominates every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            adel_q  <= misaligned(RESET_VEC);
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pc_q    <= pc_n;
            valid_q <= (state_n == S_RUN);
            adel_q  <= misaligned(pc_n);
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.adel_o     = adel_q;
    assign bus.state_o    = state_q;

endmodule
